icache: RTL and testbench
=========================

ICACHE -- requirements
Module: icache

Interface
REQ-001 SHALL have parameter N_LINES, default 64, number of direct-mapped lines (power of two).
REQ-002 SHALL have parameter WORDS_PER_LINE, default 4, 32-bit words per line (power of two, >=2).
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_n  input  1  reset, synchronous and active-low.
REQ-005 ADR_SI  input  32  fetch address from ifetch; bits [1:0] ignored.
REQ-006 ADR_VALID_SI  input  1  ifetch requests an instruction at ADR_SI this cycle.
REQ-007 IC_INST_SI  output  32  instruction word returned to ifetch.
REQ-008 IC_STALL_SI  output  1  requested word not available this cycle.
REQ-009 IC_FLUSH_SI  input  1  invalidate whole cache (fence.i).
REQ-010 MEM_REQ_SC  output  1  memory read request, held until acknowledged.
REQ-011 MEM_ADR_SC  output  32  word address of the current refill beat.
REQ-012 MEM_ACK_SM  input  1  memory accepts the request; data valid the same cycle.
REQ-013 MEM_DATA_SM  input  32  read data, sampled when MEM_ACK_SM=1.

Function
REQ-014 Address split SHALL be: offset = ADR_SI[log2(WORDS_PER_LINE)+1:2], index = next log2(N_LINES) bits, tag = remaining upper bits (22 bits at defaults).
REQ-015 Tag, valid and data arrays SHALL be flop-based with combinational read; hit = ADR_VALID_SI & valid[index] & tag match & state IDLE.
REQ-016 On hit, IC_INST_SI SHALL equal data[index][offset] and IC_STALL_SI=0 in the same cycle (zero-latency hit).
REQ-017 When not hit, IC_INST_SI SHALL be 32'h00000013 (NOP).
REQ-018 IC_STALL_SI SHALL be 1 when (ADR_VALID_SI & !hit) or state != IDLE, else 0.
REQ-019 FSM states SHALL be IDLE and REFILL only.
REQ-020 IDLE -> REFILL on ADR_VALID_SI & !hit & !IC_FLUSH_SI; latch line base address (ADR_SI with offset and [1:0] zeroed), index and tag; beat counter := 0.
REQ-021 In REFILL, MEM_REQ_SC=1 and MEM_ADR_SC = line base + 4*beat; request and address SHALL stay stable until MEM_ACK_SM.
REQ-022 On MEM_ACK_SM in REFILL, MEM_DATA_SM SHALL be written to data[latched index][beat] and beat incremented; the next beat is requested the following cycle.
REQ-023 On acknowledge of the last beat (beat = WORDS_PER_LINE-1), latched tag written, valid set, state -> IDLE; the re-presented address hits one cycle later (miss penalty = WORDS_PER_LINE acks + 1 cycle).
REQ-024 MEM_ACK_SM while MEM_REQ_SC=0 SHALL be ignored.
REQ-025 ADR_SI/ADR_VALID_SI changes during REFILL (redirect, flush of ifetch) SHALL NOT abort the refill; the line completes and the new address is looked up on return to IDLE.
REQ-026 IC_FLUSH_SI in IDLE SHALL clear all valid bits at that edge; hit is forced to 0 in that cycle.
REQ-027 IC_FLUSH_SI during REFILL SHALL clear all valid bits, let the refill finish its beats, and NOT set valid for the refilled line.
REQ-028 In IDLE, MEM_REQ_SC=0 and MEM_ADR_SC SHALL hold its last value (0 after reset).

Reset
REQ-029 With reset_n=0 at a clock edge: state := IDLE, beat := 0, all valid bits := 0, MEM_ADR_SC := 0, pending flush marker := 0; tag/data arrays not reset.
REQ-030 Reset during REFILL SHALL abandon the refill; MEM_REQ_SC=0 from the cycle after the reset edge; no line becomes valid.
REQ-031 After reset every ADR_VALID_SI request SHALL miss.

Structure
REQ-032 Shared package SHALL hold the FSM state enum, NOP constant 32'h00000013 and the default N_LINES/WORDS_PER_LINE values.
REQ-033 No sub-module is needed; arrays, FSM and beat counter SHALL live in icache; tag/valid/data arrays SHALL be inferred registers.

Verification
REQ-034 Reset, then ADR_SI=0x00000100 valid, memory acks every cycle with data 0xA0..0xA3 -> MEM_ADR_SC 0x100,0x104,0x108,0x10C; stall 5 cycles; then IC_INST_SI=0xA0, stall 0.
REQ-035 After REQ-034, ADR_SI=0x0000010C -> same-cycle hit, IC_INST_SI=0xA3, no MEM_REQ_SC.
REQ-036 ADR_SI=0x00000500 (same index 16, different tag) -> miss, refill overwrites line; 0x100 then misses again.
REQ-037 Memory inserts 3 wait cycles per beat -> MEM_REQ_SC/MEM_ADR_SC stable during waits; 16-cycle refill; correct words.
REQ-038 IC_FLUSH_SI pulsed during beat 2 of a refill -> beats complete; subsequent fetch of that line and of previously valid 0x100 both miss.
REQ-039 reset_n=0 during beat 1 -> MEM_REQ_SC low next cycle; re-fetch of that address misses and refills from beat 0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and constants for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {IDLE, REFILL} state_t;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam int DEF_N_LINES        = 64;
    localparam int DEF_WORDS_PER_LINE = 4;

endpackage

// File: rtl/icache.sv
// Direct-mapped instruction cache: zero-latency flop-array hits, blocking
// line refill one word per memory acknowledge.
module icache
    import icache_pkg::*;
#(
    parameter int N_LINES        = DEF_N_LINES,
    parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ADR_SI,
    input  logic        ADR_VALID_SI,
    output logic [31:0] IC_INST_SI,
    output logic        IC_STALL_SI,
    input  logic        IC_FLUSH_SI,
    output logic        MEM_REQ_SC,
    output logic [31:0] MEM_ADR_SC,
    input  logic        MEM_ACK_SM,
    input  logic [31:0] MEM_DATA_SM
);

    localparam int OFF_W = $clog2(WORDS_PER_LINE);
    localparam int IDX_W = $clog2(N_LINES);
    localparam int LO_W  = OFF_W + 2;
    localparam int TAG_W = 32 - LO_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

    state_t             state;
    logic [OFF_W-1:0]   beat;
    logic [N_LINES-1:0] valid;
    logic [TAG_W-1:0]   tags [N_LINES];
    logic [31:0]        data [N_LINES][WORDS_PER_LINE];
    logic [IDX_W-1:0]   ref_idx;
    logic [TAG_W-1:0]   ref_tag;
    logic               flush_pend;

    logic [OFF_W-1:0]   off;
    logic [IDX_W-1:0]   idx;
    logic [TAG_W-1:0]   tag;
    logic               hit;
    logic               miss;
    logic               beat_ack;
    logic               last_ack;
    logic [1:0]         unused_adr;

    assign off        = ADR_SI[2 +: OFF_W];
    assign idx        = ADR_SI[LO_W +: IDX_W];
    assign tag        = ADR_SI[31 -: TAG_W];
    assign unused_adr = ADR_SI[1:0];

    // A flush cycle never hits, even though the arrays still hold the line.
    assign hit = ADR_VALID_SI && valid[idx] && (tags[idx] == tag)
              && (state == IDLE) && !IC_FLUSH_SI;
    assign miss = ADR_VALID_SI && !hit;

    assign IC_INST_SI  = hit ? data[idx][off] : NOP;
    assign IC_STALL_SI = miss || (state != IDLE);
    assign MEM_REQ_SC  = (state == REFILL);

    assign beat_ack = MEM_REQ_SC && MEM_ACK_SM;
    assign last_ack = beat_ack && (beat == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= IDLE;
            beat       <= '0;
            valid      <= '0;
            MEM_ADR_SC <= '0;
            flush_pend <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (miss && !IC_FLUSH_SI) begin
                        state      <= REFILL;
                        beat       <= '0;
                        ref_idx    <= idx;
                        ref_tag    <= tag;
                        MEM_ADR_SC <= {ADR_SI[31:LO_W], LO_W'(0)};
                    end
                end
                REFILL: begin
                    if (beat_ack) begin
                        beat <= beat + 1'b1;
                        // Address stays on the last beat so it holds through IDLE.
                        if (last_ack) state <= IDLE;
                        else          MEM_ADR_SC <= MEM_ADR_SC + 32'd4;
                    end
                end
                default: state <= IDLE;
            endcase

            // A flush seen anywhere in the refill keeps the refilled line invalid.
            if (IC_FLUSH_SI)                    valid <= '0;
            else if (last_ack && !flush_pend)   valid[ref_idx] <= 1'b1;

            if (last_ack)                            flush_pend <= 1'b0;
            else if (IC_FLUSH_SI && state == REFILL) flush_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset_n && beat_ack) begin
            data[ref_idx][beat] <= MEM_DATA_SM;
            if (last_ack) tags[ref_idx] <= ref_tag;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Randomized bench for icache against a line-level cache/memory reference model.
module tb_icache;

    localparam logic [31:0] NOP_W = 32'h0000_0013;
    localparam int WPL = 4;
    localparam int NL  = 64;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [31:0] ADR_SI;
    logic        ADR_VALID_SI;
    logic [31:0] IC_INST_SI;
    logic        IC_STALL_SI;
    logic        IC_FLUSH_SI;
    logic        MEM_REQ_SC;
    logic [31:0] MEM_ADR_SC;
    logic        MEM_ACK_SM;
    logic [31:0] MEM_DATA_SM;

    icache dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ADR_SI       (ADR_SI),
        .ADR_VALID_SI (ADR_VALID_SI),
        .IC_INST_SI   (IC_INST_SI),
        .IC_STALL_SI  (IC_STALL_SI),
        .IC_FLUSH_SI  (IC_FLUSH_SI),
        .MEM_REQ_SC   (MEM_REQ_SC),
        .MEM_ADR_SC   (MEM_ADR_SC),
        .MEM_ACK_SM   (MEM_ACK_SM),
        .MEM_DATA_SM  (MEM_DATA_SM)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference state: which memory line each cache slot holds.
    bit          m_valid [NL];
    int unsigned m_tag   [NL];
    logic [31:0] last_adr;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
    endfunction

    function automatic void model_clear();
        for (int i = 0; i < NL; i++) m_valid[i] = 1'b0;
    endfunction

    task automatic do_reset();
        reset_n = 1'b0; ADR_VALID_SI = 1'b0; ADR_SI = '0; IC_FLUSH_SI = 1'b0;
        MEM_ACK_SM = 1'b0; MEM_DATA_SM = '0;
        repeat (2) @(posedge clk);
        #1 reset_n = 1'b1;
        model_clear();
        last_adr = '0;
        @(negedge clk);
        chk("rst_req", {31'b0, MEM_REQ_SC}, 32'd0);
        chk("rst_adr", MEM_ADR_SC, 32'd0);
        chk("rst_stall", {31'b0, IC_STALL_SI}, 32'd0);
        chk("rst_inst", IC_INST_SI, NOP_W);
        @(posedge clk); #1;
    endtask

    task automatic idle_cycle();
        ADR_VALID_SI = 1'b0; ADR_SI = $urandom; IC_FLUSH_SI = 1'b0;
        MEM_ACK_SM = 1'($urandom_range(0, 1)); MEM_DATA_SM = $urandom;
        @(negedge clk);
        chk("idle_req", {31'b0, MEM_REQ_SC}, 32'd0);
        chk("idle_adr", MEM_ADR_SC, last_adr);
        chk("idle_stall", {31'b0, IC_STALL_SI}, 32'd0);
        @(posedge clk); #1;
    endtask

    // Entered and left just after a rising edge. Returns stalled cycles seen.
    task automatic fetch(input logic [31:0] a, input int wlo, input int whi,
                         input int flush_beat, input int rst_beat,
                         input bit redirect, input bit idle_flush, output int stalls);
        int unsigned ix, tg;
        logic [31:0] base;
        bit hit, flushed;
        int w;
        ix = (a >> 4) % NL;
        tg = a >> 10;
        base = a & ~32'hF;
        stalls = 0;
        flushed = 1'b0;

        ADR_SI = a; ADR_VALID_SI = 1'b1; IC_FLUSH_SI = idle_flush;
        MEM_ACK_SM = 1'($urandom_range(0, 1)); MEM_DATA_SM = $urandom;
        @(negedge clk);
        hit = !idle_flush && m_valid[ix] && m_tag[ix] == tg;
        chk("look_stall", {31'b0, IC_STALL_SI}, {31'b0, !hit});
        chk("look_inst", IC_INST_SI, hit ? mem_word(a & ~32'h3) : NOP_W);
        chk("look_req", {31'b0, MEM_REQ_SC}, 32'd0);
        chk("look_adr", MEM_ADR_SC, last_adr);
        stalls += int'(IC_STALL_SI);
        if (idle_flush) begin
            model_clear();
            @(posedge clk); #1;
            IC_FLUSH_SI = 1'b0; MEM_ACK_SM = 1'b0;
            @(negedge clk);
            chk("iflush_noreq", {31'b0, MEM_REQ_SC}, 32'd0);
            chk("iflush_stall", {31'b0, IC_STALL_SI}, 32'd1);
            stalls += int'(IC_STALL_SI);
            hit = 1'b0;
        end
        if (hit) begin
            @(posedge clk); #1;
            MEM_ACK_SM = 1'b0;
            return;
        end

        for (int b = 0; b < WPL; b++) begin
            w = $urandom_range(wlo, whi);
            for (int k = 0; k <= w; k++) begin
                @(posedge clk); #1;
                MEM_ACK_SM  = (k == w);
                MEM_DATA_SM = (k == w) ? mem_word(base + 32'(4 * b)) : $urandom;
                IC_FLUSH_SI = (b == flush_beat && k == 0);
                if (redirect) begin
                    ADR_SI = $urandom; ADR_VALID_SI = 1'($urandom_range(0, 1));
                end
                if (b == rst_beat && k == 0) begin
                    reset_n = 1'b0; MEM_ACK_SM = 1'b0;
                end
                if (IC_FLUSH_SI) begin
                    flushed = 1'b1;
                    model_clear();
                end
                @(negedge clk);
                chk("ref_req", {31'b0, MEM_REQ_SC}, 32'd1);
                chk("ref_adr", MEM_ADR_SC, base + 32'(4 * b));
                chk("ref_stall", {31'b0, IC_STALL_SI}, 32'd1);
                chk("ref_inst", IC_INST_SI, NOP_W);
                stalls += int'(IC_STALL_SI);
                if (!reset_n) begin
                    @(posedge clk); #1;
                    reset_n = 1'b1; ADR_VALID_SI = 1'b0; MEM_ACK_SM = 1'b0; IC_FLUSH_SI = 1'b0;
                    model_clear();
                    last_adr = '0;
                    @(negedge clk);
                    chk("abort_req", {31'b0, MEM_REQ_SC}, 32'd0);
                    chk("abort_adr", MEM_ADR_SC, 32'd0);
                    chk("abort_stall", {31'b0, IC_STALL_SI}, 32'd0);
                    @(posedge clk); #1;
                    return;
                end
            end
        end

        if (!flushed) begin
            m_valid[ix] = 1'b1;
            m_tag[ix]   = tg;
        end
        last_adr = base + 32'(4 * (WPL - 1));
        @(posedge clk); #1;
        ADR_SI = a; ADR_VALID_SI = 1'b1; IC_FLUSH_SI = 1'b0;
        MEM_ACK_SM = 1'($urandom_range(0, 1)); MEM_DATA_SM = $urandom;
        @(negedge clk);
        chk("fin_stall", {31'b0, IC_STALL_SI}, {31'b0, flushed});
        chk("fin_inst", IC_INST_SI, flushed ? NOP_W : mem_word(a & ~32'h3));
        chk("fin_req", {31'b0, MEM_REQ_SC}, 32'd0);
        chk("fin_adr", MEM_ADR_SC, last_adr);
        stalls += int'(IC_STALL_SI);
        // Keep a still-missing address from starting another refill.
        ADR_VALID_SI = 1'b0;
        @(posedge clk); #1;
        MEM_ACK_SM = 1'b0;
    endtask

    initial begin
        int st;
        logic [31:0] a;
        do_reset();

        mem[32'h100] = 32'hA0; mem[32'h104] = 32'hA1;
        mem[32'h108] = 32'hA2; mem[32'h10C] = 32'hA3;

        fetch(32'h100, 0, 0, -1, -1, 1'b0, 1'b0, st);
        chk("d_miss_stalls", 32'(st), 32'd5);
        fetch(32'h10C, 0, 0, -1, -1, 1'b0, 1'b0, st);
        chk("d_hit_stalls", 32'(st), 32'd0);
        fetch(32'h500, 0, 0, -1, -1, 1'b0, 1'b0, st);
        chk("d_alias_stalls", 32'(st), 32'd5);
        fetch(32'h100, 0, 0, -1, -1, 1'b0, 1'b0, st);
        chk("d_evict_stalls", 32'(st), 32'd5);
        fetch(32'h200, 3, 3, -1, -1, 1'b0, 1'b0, st);
        chk("d_wait_stalls", 32'(st), 32'd17);
        fetch(32'h300, 0, 0, 2, -1, 1'b0, 1'b0, st);
        fetch(32'h300, 0, 0, -1, -1, 1'b0, 1'b0, st);
        chk("d_flush_line", 32'(st), 32'd5);
        fetch(32'h100, 0, 0, -1, -1, 1'b0, 1'b0, st);
        chk("d_flush_old", 32'(st), 32'd5);
        fetch(32'h600, 0, 0, -1, 1, 1'b0, 1'b0, st);
        fetch(32'h600, 0, 0, -1, -1, 1'b0, 1'b0, st);
        chk("d_rst_refetch", 32'(st), 32'd5);
        idle_cycle();

        for (int t = 0; t < 400; t++) begin
            a = (32'($urandom_range(0, 3)) << 10) | (32'($urandom_range(0, 7)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) idle_cycle();
            fetch(a, 0, $urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? int'($urandom_range(0, 3)) : -1,
                  ($urandom_range(0, 24) == 0) ? int'($urandom_range(0, 3)) : -1,
                  ($urandom_range(0, 3) == 0), ($urandom_range(0, 11) == 0), st);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
